// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline datapath.
//   - Addressing-mode encodings consumed by the EX shifter/sign-extender.
//   - PC_REG: register index that is never forwarded; decode supplies PC+8 for it.
//   - ALU opcode constants (ARM data-processing encoding).
//   - ex_ctrl_t and EX_CTRL_BUBBLE: the ID/EX control bundle and its all-zero bubble value.
package arm_pipe_pkg;

  localparam int unsigned PC_REG = 15;

  typedef enum logic [1:0] {
    AM_IMM32     = 2'b00,
    AM_SHIFT_REG = 2'b01,
    AM_IMM12     = 2'b10,
    AM_REG       = 2'b11
  } am_e;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_EOR = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_RSB = 4'h3;
  localparam logic [3:0] ALU_ADD = 4'h4;
  localparam logic [3:0] ALU_ADC = 4'h5;
  localparam logic [3:0] ALU_SBC = 4'h6;
  localparam logic [3:0] ALU_RSC = 4'h7;
  localparam logic [3:0] ALU_TST = 4'h8;
  localparam logic [3:0] ALU_TEQ = 4'h9;
  localparam logic [3:0] ALU_CMP = 4'hA;
  localparam logic [3:0] ALU_CMN = 4'hB;
  localparam logic [3:0] ALU_ORR = 4'hC;
  localparam logic [3:0] ALU_MOV = 4'hD;
  localparam logic [3:0] ALU_BIC = 4'hE;
  localparam logic [3:0] ALU_MVN = 4'hF;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic        s;
    logic        load;
    logic        store;
    logic        rf_we;
    logic [11:0] imm;
    logic [1:0]  am;
  } ex_ctrl_t;

  // A bubble carries no side effects: invalid and every control bit low.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding mux for one register source operand.
//   addr, use_src, rf_data      : source index, read flag and register-file data
//   ex_*/mem_*/wb_*             : in-flight destination, write enable and result per stage
//   ex_is_load                  : EX producer is a load (its result is not ready yet)
//   data                        : resolved operand (EX > MEM > WB > register file)
//   ex_load_hit                 : source depends on the load in EX; caller must stall
module fwd_mux
  import arm_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 4,
  parameter int unsigned PC_IDX  = PC_REG
) (
  input  logic [RADDR_W-1:0] addr,
  input  logic               use_src,
  input  logic [DATA_W-1:0]  rf_data,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_we,
  input  logic               ex_is_load,
  input  logic [DATA_W-1:0]  ex_data,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic               mem_we,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic               wb_we,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [DATA_W-1:0]  data,
  output logic               ex_load_hit
);

  localparam logic [RADDR_W-1:0] PcAddr = RADDR_W'(PC_IDX);

  logic fwd_ok;
  logic hit_ex, hit_mem, hit_wb;

  // The PC read always comes from decode (PC+8), never from a producer.
  assign fwd_ok  = use_src & (addr != PcAddr);
  assign hit_ex  = fwd_ok & ex_we  & (ex_rd  == addr);
  assign hit_mem = fwd_ok & mem_we & (mem_rd == addr);
  assign hit_wb  = fwd_ok & wb_we  & (wb_rd  == addr);

  assign ex_load_hit = hit_ex & ex_is_load;

  // A load hit in EX falls through to older stages; the stage bubbles anyway.
  always_comb begin
    data = rf_data;
    if (hit_ex && !ex_is_load) begin
      data = ex_data;
    end else if (hit_mem) begin
      data = mem_data;
    end else if (hit_wb) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall.
//   Inputs : decode slot (id_*), in-flight producers (ex_*/mem_*/wb_*), flush.
//   Outputs: stall (combinational), registered operands ex_rn/ex_rm/ex_rdv, destination
//            ex_rd_addr, pass-through ex_i/ex_am, control bits ex_valid/alu_op/s/load/
//            store/rf_we.
// Reset is synchronous and active-high; a stall, a flush or an empty decode slot latch a
// fully zeroed bubble.
module id_ex_operand_stage
  import arm_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 4,
  parameter int unsigned PC_REG  = arm_pipe_pkg::PC_REG
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rn_addr,
  input  logic [RADDR_W-1:0] id_rm_addr,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic               id_use_rn,
  input  logic               id_use_rm,
  input  logic               id_use_rd,
  input  logic [DATA_W-1:0]  id_rn_data,
  input  logic [DATA_W-1:0]  id_rm_data,
  input  logic [DATA_W-1:0]  id_rd_data,
  input  logic [11:0]        id_i,
  input  logic [1:0]         id_am,
  input  logic [3:0]         id_alu_op,
  input  logic               id_s,
  input  logic               id_load,
  input  logic               id_store,
  input  logic               id_rf_we,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic               ex_we,
  input  logic               mem_we,
  input  logic               wb_we,
  input  logic               ex_is_load,
  input  logic [DATA_W-1:0]  ex_fwd_data,
  input  logic [DATA_W-1:0]  mem_fwd_data,
  input  logic [DATA_W-1:0]  wb_fwd_data,
  input  logic               flush,
  output logic               stall,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_rn,
  output logic [DATA_W-1:0]  ex_rm,
  output logic [DATA_W-1:0]  ex_rdv,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic [11:0]        ex_i,
  output logic [1:0]         ex_am,
  output logic [3:0]         ex_alu_op,
  output logic               ex_s,
  output logic               ex_load,
  output logic               ex_store,
  output logic               ex_rf_we
);

  logic [DATA_W-1:0] rn_fwd, rm_fwd, rd_fwd;
  logic              rn_ld_hit, rm_ld_hit, rd_ld_hit;
  logic              capture;

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .PC_IDX(PC_REG)) u_fwd_rn (
    .addr        (id_rn_addr),
    .use_src     (id_use_rn),
    .rf_data     (id_rn_data),
    .ex_rd       (ex_rd),
    .ex_we       (ex_we),
    .ex_is_load  (ex_is_load),
    .ex_data     (ex_fwd_data),
    .mem_rd      (mem_rd),
    .mem_we      (mem_we),
    .mem_data    (mem_fwd_data),
    .wb_rd       (wb_rd),
    .wb_we       (wb_we),
    .wb_data     (wb_fwd_data),
    .data        (rn_fwd),
    .ex_load_hit (rn_ld_hit)
  );

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .PC_IDX(PC_REG)) u_fwd_rm (
    .addr        (id_rm_addr),
    .use_src     (id_use_rm),
    .rf_data     (id_rm_data),
    .ex_rd       (ex_rd),
    .ex_we       (ex_we),
    .ex_is_load  (ex_is_load),
    .ex_data     (ex_fwd_data),
    .mem_rd      (mem_rd),
    .mem_we      (mem_we),
    .mem_data    (mem_fwd_data),
    .wb_rd       (wb_rd),
    .wb_we       (wb_we),
    .wb_data     (wb_fwd_data),
    .data        (rm_fwd),
    .ex_load_hit (rm_ld_hit)
  );

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .PC_IDX(PC_REG)) u_fwd_rd (
    .addr        (id_rd_addr),
    .use_src     (id_use_rd),
    .rf_data     (id_rd_data),
    .ex_rd       (ex_rd),
    .ex_we       (ex_we),
    .ex_is_load  (ex_is_load),
    .ex_data     (ex_fwd_data),
    .mem_rd      (mem_rd),
    .mem_we      (mem_we),
    .mem_data    (mem_fwd_data),
    .wb_rd       (wb_rd),
    .wb_we       (wb_we),
    .wb_data     (wb_fwd_data),
    .data        (rd_fwd),
    .ex_load_hit (rd_ld_hit)
  );

  // Flush wins: holding fetch for an instruction being killed would be pointless.
  assign stall   = id_valid & ~flush & (rn_ld_hit | rm_ld_hit | rd_ld_hit);
  assign capture = id_valid & ~stall & ~flush;

  ex_ctrl_t          ctrl_d, ctrl_q;
  logic [DATA_W-1:0] rn_d, rn_q, rm_d, rm_q, rdv_d, rdv_q;
  logic [RADDR_W-1:0] rd_addr_d, rd_addr_q;

  always_comb begin
    ctrl_d    = EX_CTRL_BUBBLE;
    rn_d      = '0;
    rm_d      = '0;
    rdv_d     = '0;
    rd_addr_d = '0;
    if (capture) begin
      ctrl_d.valid  = 1'b1;
      ctrl_d.alu_op = id_alu_op;
      ctrl_d.s      = id_s;
      ctrl_d.load   = id_load;
      ctrl_d.store  = id_store;
      ctrl_d.rf_we  = id_rf_we;
      ctrl_d.imm    = id_i;
      ctrl_d.am     = id_am;
      rn_d          = rn_fwd;
      rm_d          = rm_fwd;
      rdv_d         = rd_fwd;
      rd_addr_d     = id_rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= EX_CTRL_BUBBLE;
      rn_q      <= '0;
      rm_q      <= '0;
      rdv_q     <= '0;
      rd_addr_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rn_q      <= rn_d;
      rm_q      <= rm_d;
      rdv_q     <= rdv_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign ex_valid   = ctrl_q.valid;
  assign ex_alu_op  = ctrl_q.alu_op;
  assign ex_s       = ctrl_q.s;
  assign ex_load    = ctrl_q.load;
  assign ex_store   = ctrl_q.store;
  assign ex_rf_we   = ctrl_q.rf_we;
  assign ex_i       = ctrl_q.imm;
  assign ex_am      = ctrl_q.am;
  assign ex_rn      = rn_q;
  assign ex_rm      = rm_q;
  assign ex_rdv     = rdv_q;
  assign ex_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed table, hand-written multi-cycle
// sequences (reset, load-use recovery) and random stimulus against a behavioural model.
module tb_id_ex_operand_stage;

  typedef struct packed {
    logic        reset;
    logic        id_valid;
    logic [3:0]  rn_a, rm_a, rd_a;
    logic        use_rn, use_rm, use_rd;
    logic [31:0] rn_d, rm_d, rd_d;
    logic [11:0] i;
    logic [1:0]  am;
    logic [3:0]  alu_op;
    logic        s, load, store, rf_we;
    logic [3:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_we, mem_we, wb_we, ex_is_load;
    logic [31:0] ex_f, mem_f, wb_f;
    logic        flush;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rn, rm, rdv;
    logic [3:0]  rd_addr;
    logic [11:0] i;
    logic [1:0]  am;
    logic [3:0]  alu_op;
    logic        s, load, store, rf_we;
  } out_t;

  typedef struct {
    string       name;
    stim_t       s;
    logic        stall;
    logic        valid;
    logic [31:0] rn, rm, rdv;
    logic [11:0] i;
    logic [1:0]  am;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, id_valid, id_use_rn, id_use_rm, id_use_rd;
  logic [3:0] id_rn_addr, id_rm_addr, id_rd_addr, id_alu_op, ex_rd, mem_rd, wb_rd;
  logic [31:0] id_rn_data, id_rm_data, id_rd_data, ex_fwd_data, mem_fwd_data, wb_fwd_data;
  logic [11:0] id_i;
  logic [1:0] id_am;
  logic id_s, id_load, id_store, id_rf_we, ex_we, mem_we, wb_we, ex_is_load, flush;
  logic stall, ex_valid, ex_s, ex_load, ex_store, ex_rf_we;
  logic [31:0] ex_rn, ex_rm, ex_rdv;
  logic [3:0] ex_rd_addr, ex_alu_op;
  logic [11:0] ex_i;
  logic [1:0] ex_am;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rn_addr(id_rn_addr), .id_rm_addr(id_rm_addr), .id_rd_addr(id_rd_addr),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_rn_data(id_rn_data), .id_rm_data(id_rm_data), .id_rd_data(id_rd_data),
    .id_i(id_i), .id_am(id_am), .id_alu_op(id_alu_op), .id_s(id_s),
    .id_load(id_load), .id_store(id_store), .id_rf_we(id_rf_we),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_is_load(ex_is_load),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rdv(ex_rdv), .ex_rd_addr(ex_rd_addr),
    .ex_i(ex_i), .ex_am(ex_am), .ex_alu_op(ex_alu_op), .ex_s(ex_s),
    .ex_load(ex_load), .ex_store(ex_store), .ex_rf_we(ex_rf_we)
  );

  out_t act;
  assign act = '{valid: ex_valid, rn: ex_rn, rm: ex_rm, rdv: ex_rdv, rd_addr: ex_rd_addr,
                 i: ex_i, am: ex_am, alu_op: ex_alu_op, s: ex_s, load: ex_load,
                 store: ex_store, rf_we: ex_rf_we};

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic apply(input stim_t s);
    reset = s.reset;  id_valid = s.id_valid;  flush = s.flush;
    id_rn_addr = s.rn_a;  id_rm_addr = s.rm_a;  id_rd_addr = s.rd_a;
    id_use_rn = s.use_rn;  id_use_rm = s.use_rm;  id_use_rd = s.use_rd;
    id_rn_data = s.rn_d;  id_rm_data = s.rm_d;  id_rd_data = s.rd_d;
    id_i = s.i;  id_am = s.am;  id_alu_op = s.alu_op;  id_s = s.s;
    id_load = s.load;  id_store = s.store;  id_rf_we = s.rf_we;
    ex_rd = s.ex_rd;  mem_rd = s.mem_rd;  wb_rd = s.wb_rd;
    ex_we = s.ex_we;  mem_we = s.mem_we;  wb_we = s.wb_we;  ex_is_load = s.ex_is_load;
    ex_fwd_data = s.ex_f;  mem_fwd_data = s.mem_f;  wb_fwd_data = s.wb_f;
  endtask

  // Producers are scanned oldest to youngest; the youngest matching writer overwrites.
  function automatic logic [31:0] resolve(input stim_t s, input logic use_src,
                                          input logic [3:0] a, input logic [31:0] rf,
                                          output logic ld_hit);
    logic [3:0]  prd [3];
    logic        pwe [3];
    logic [31:0] pdat [3];
    logic [31:0] r;
    prd[0] = s.ex_rd;  pwe[0] = s.ex_we;  pdat[0] = s.ex_f;
    prd[1] = s.mem_rd; pwe[1] = s.mem_we; pdat[1] = s.mem_f;
    prd[2] = s.wb_rd;  pwe[2] = s.wb_we;  pdat[2] = s.wb_f;
    r = rf;
    ld_hit = 1'b0;
    if (use_src && a != 4'd15) begin
      for (int k = 2; k >= 0; k--) begin
        if (pwe[k] && prd[k] == a) begin
          r = pdat[k];
          if (k == 0 && s.ex_is_load) ld_hit = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic model(input stim_t s, output logic st, output out_t o);
    logic h0, h1, h2;
    logic [31:0] vn, vm, vd;
    vn = resolve(s, s.use_rn, s.rn_a, s.rn_d, h0);
    vm = resolve(s, s.use_rm, s.rm_a, s.rm_d, h1);
    vd = resolve(s, s.use_rd, s.rd_a, s.rd_d, h2);
    st = s.id_valid && !s.flush && (h0 || h1 || h2);
    o = '0;
    if (!s.reset && s.id_valid && !st && !s.flush) begin
      o = '{valid: 1'b1, rn: vn, rm: vm, rdv: vd, rd_addr: s.rd_a, i: s.i, am: s.am,
            alu_op: s.alu_op, s: s.s, load: s.load, store: s.store, rf_we: s.rf_we};
    end
  endtask

  function automatic stim_t base();
    stim_t s = '0;
    s.id_valid = 1'b1;
    s.rn_a = 4'd1;  s.rm_a = 4'd2;  s.rd_a = 4'd4;
    s.use_rn = 1'b1;  s.use_rm = 1'b1;  s.use_rd = 1'b1;
    s.rn_d = 32'h1111;  s.rm_d = 32'h2222;  s.rd_d = 32'h4444;
    s.i = 12'h0AB;  s.am = 2'b01;  s.alu_op = 4'h4;  s.rf_we = 1'b1;
    return s;
  endfunction

  task automatic run_model_cycle(input stim_t s, input string tag);
    logic est;
    out_t eo;
    apply(s);
    model(s, est, eo);
    #1;
    chk({tag, ".stall"}, 128'(stall), 128'(est));
    @(posedge clk);
    #1;
    chk({tag, ".regs"}, 128'(act), 128'(eo));
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    stim_t s;

    // ---- directed table ----
    v.name = "base"; v.s = base(); v.stall = 0; v.valid = 1;
    v.rn = 32'h1111; v.rm = 32'h2222; v.rdv = 32'h4444; v.i = 12'h0AB; v.am = 2'b01;
    tbl.push_back(v);

    v.name = "ex_fwd"; v.s = base();
    v.s.rm_a = 4'd3; v.s.rm_d = 32'h11; v.s.ex_rd = 4'd3; v.s.ex_we = 1;
    v.s.ex_f = 32'hDEADBEEF;
    v.rm = 32'hDEADBEEF;
    tbl.push_back(v);

    v.name = "prio_ex"; v.s = base();
    v.s.rn_a = 4'd5; v.s.ex_rd = 4'd5; v.s.mem_rd = 4'd5; v.s.wb_rd = 4'd5;
    v.s.ex_we = 1; v.s.mem_we = 1; v.s.wb_we = 1;
    v.s.ex_f = 32'hA; v.s.mem_f = 32'hB; v.s.wb_f = 32'hC;
    v.rn = 32'hA; v.rm = 32'h2222;
    tbl.push_back(v);
    v.name = "prio_mem"; v.s.ex_we = 0; v.rn = 32'hB; tbl.push_back(v);
    v.name = "prio_wb"; v.s.mem_we = 0; v.rn = 32'hC; tbl.push_back(v);

    v.name = "flush_over_stall"; v.s = base();
    v.s.ex_is_load = 1; v.s.ex_rd = 4'd2; v.s.ex_we = 1; v.s.ex_f = 32'h999; v.s.flush = 1;
    v.stall = 0; v.valid = 0; v.rn = 0; v.rm = 0; v.rdv = 0; v.i = 0; v.am = 0;
    tbl.push_back(v);

    v.name = "load_no_use"; v.s.flush = 0; v.s.use_rm = 0;
    v.stall = 0; v.valid = 1; v.rn = 32'h1111; v.rm = 32'h2222; v.rdv = 32'h4444;
    v.i = 12'h0AB; v.am = 2'b01;
    tbl.push_back(v);

    v.name = "load_use_rd"; v.s = base();
    v.s.ex_is_load = 1; v.s.ex_rd = 4'd4; v.s.ex_we = 1;
    v.stall = 1; v.valid = 0; v.rn = 0; v.rm = 0; v.rdv = 0; v.i = 0; v.am = 0;
    tbl.push_back(v);

    v.name = "r15_imm"; v.s = base();
    v.s.rn_a = 4'd15; v.s.rn_d = 32'h108; v.s.ex_rd = 4'd15; v.s.ex_we = 1;
    v.s.ex_f = 32'hBAD; v.s.i = 12'h26C; v.s.am = 2'b10;
    v.stall = 0; v.valid = 1; v.rn = 32'h108; v.rm = 32'h2222; v.rdv = 32'h4444;
    v.i = 12'h26C; v.am = 2'b10;
    tbl.push_back(v);
    v.name = "r15_load"; v.s.ex_is_load = 1; tbl.push_back(v);

    v.name = "mixed_stages"; v.s = base();
    v.s.ex_rd = 4'd1; v.s.ex_we = 1; v.s.ex_f = 32'hE0;
    v.s.mem_rd = 4'd2; v.s.mem_we = 1; v.s.mem_f = 32'hE1;
    v.s.wb_rd = 4'd4; v.s.wb_we = 1; v.s.wb_f = 32'hE2;
    v.stall = 0; v.valid = 1; v.rn = 32'hE0; v.rm = 32'hE1; v.rdv = 32'hE2;
    v.i = 12'h0AB; v.am = 2'b01;
    tbl.push_back(v);

    v.name = "idle"; v.s = base(); v.s.id_valid = 0;
    v.stall = 0; v.valid = 0; v.rn = 0; v.rm = 0; v.rdv = 0; v.i = 0; v.am = 0;
    tbl.push_back(v);

    // ---- reset: every input nonzero, one edge ----
    s = '1;
    apply(s);
    @(posedge clk);
    #1;
    chk("reset.regs", 128'(act), 128'(0));
    s = base();
    apply(s);
    @(posedge clk);
    #1;
    chk("post_reset.valid", 128'(ex_valid), 128'(1));
    chk("post_reset.alu_op", 128'(ex_alu_op), 128'(4'h4));
    chk("post_reset.rn", 128'(ex_rn), 128'(32'h1111));

    foreach (tbl[k]) begin
      apply(tbl[k].s);
      #1;
      chk({tbl[k].name, ".stall"}, 128'(stall), 128'(tbl[k].stall));
      @(posedge clk);
      #1;
      chk({tbl[k].name, ".valid"}, 128'(ex_valid), 128'(tbl[k].valid));
      chk({tbl[k].name, ".rn"}, 128'(ex_rn), 128'(tbl[k].rn));
      chk({tbl[k].name, ".rm"}, 128'(ex_rm), 128'(tbl[k].rm));
      chk({tbl[k].name, ".rdv"}, 128'(ex_rdv), 128'(tbl[k].rdv));
      chk({tbl[k].name, ".i_am"}, 128'({ex_i, ex_am}), 128'({tbl[k].i, tbl[k].am}));
    end

    // ---- load-use then recovery through MEM ----
    s = base();
    s.ex_is_load = 1; s.ex_rd = 4'd2; s.ex_we = 1; s.ex_f = 32'h999;
    apply(s);
    #1;
    chk("lu.stall1", 128'(stall), 128'(1));
    @(posedge clk);
    #1;
    chk("lu.bubble", 128'(ex_valid), 128'(0));
    s.ex_is_load = 0; s.ex_we = 0; s.mem_rd = 4'd2; s.mem_we = 1; s.mem_f = 32'h1234;
    apply(s);
    #1;
    chk("lu.stall2", 128'(stall), 128'(0));
    @(posedge clk);
    #1;
    chk("lu.rm", 128'(ex_rm), 128'(32'h1234));
    chk("lu.valid", 128'(ex_valid), 128'(1));

    // ---- random against the model ----
    for (int n = 0; n < 400; n++) begin
      s = '0;
      s.reset = ($urandom_range(0, 19) == 0);
      s.id_valid = ($urandom_range(0, 7) != 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.rn_a = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      s.rm_a = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      s.rd_a = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      s.use_rn = 1'($urandom); s.use_rm = 1'($urandom); s.use_rd = 1'($urandom);
      s.rn_d = $urandom; s.rm_d = $urandom; s.rd_d = $urandom;
      s.i = 12'($urandom); s.am = 2'($urandom); s.alu_op = 4'($urandom);
      s.s = 1'($urandom); s.load = 1'($urandom); s.store = 1'($urandom);
      s.rf_we = 1'($urandom);
      s.ex_rd = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      s.mem_rd = 4'($urandom_range(0, 3));
      s.wb_rd = 4'($urandom_range(0, 3));
      s.ex_we = 1'($urandom); s.mem_we = 1'($urandom); s.wb_we = 1'($urandom);
      s.ex_is_load = ($urandom_range(0, 3) == 0);
      s.ex_f = $urandom; s.mem_f = $urandom; s.wb_f = $urandom;
      run_model_cycle(s, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline register for the ARM datapath.
- Captures register-file operands (Rn, Rm, Rd) and shifter controls (I, AM), resolving RAW hazards with EX/MEM/WB forwarding muxes before the register.
- Detects load-use hazards and raises a stall; accepts a branch flush.
- Its registered Rm/I/AM outputs drive the shifter/sign-extender in EX.

Parameters:
- DATA_W, 32, operand and result width.
- RADDR_W, 4, register address width (R0–R15).
- PC_REG, 15, register index never forwarded (decode supplies PC+8).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rn_addr, id_rm_addr, id_rd_addr  in  RADDR_W each  source/dest indices.
- id_use_rn, id_use_rm, id_use_rd  in  1 each  instruction actually reads that source (Rd is read for stores).
- id_rn_data, id_rm_data, id_rd_data  in  DATA_W each  register-file read data.
- id_i  in  12  immediate field.
- id_am  in  2  addressing mode.
- id_alu_op  in  4  ALU opcode.
- id_s  in  1  set-flags.
- id_load, id_store, id_rf_we  in  1 each  control bits.
- ex_rd, mem_rd, wb_rd  in  RADDR_W each  in-flight destinations.
- ex_we, mem_we, wb_we  in  1 each  destination write enables (already valid-qualified).
- ex_is_load  in  1  EX instruction is a load.
- ex_fwd_data, mem_fwd_data, wb_fwd_data  in  DATA_W each  forwardable results.
- flush  in  1  branch taken; kill the decode instruction.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  registered instruction valid.
- ex_rn, ex_rm, ex_rdv  out  DATA_W each  registered resolved operands.
- ex_rd_addr  out  RADDR_W  registered destination.
- ex_i  out  12  registered immediate.
- ex_am  out  2  registered addressing mode.
- ex_alu_op  out  4  registered ALU opcode.
- ex_s, ex_load, ex_store, ex_rf_we  out  1 each  registered control bits.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - On reset at a clock edge, every registered output becomes 0.
  - stall is combinational and reads 0 only when its inputs are benign; reset itself does not gate stall.
- Forwarding, evaluated independently for each source S in {rn, rm, rd}:
  - Condition: src_hit_X = id_use_S & X_we & (X_rd == id_S_addr) & (id_S_addr != PC_REG).
  - Priority: EX > MEM > WB > register-file data (youngest producer wins).
  - An EX hit on a load never forwards ex_fwd_data; it causes a stall instead.
- Load-use hazard:
  - stall = id_valid & ex_is_load & ex_we & any(id_use_S & id_S_addr == ex_rd & id_S_addr != PC_REG).
  - While stall=1 the stage latches a bubble: ex_valid=0 and all control bits 0. Data fields are don't-care but are zeroed.
  - The following cycle the load sits in MEM; the held decode instruction resolves via MEM forwarding and stall drops.
  - Stall lasts exactly 1 cycle per load-use hazard.
- Flush:
  - flush=1 latches a bubble, exactly as for a stall.
  - flush takes precedence over stall, so stall is forced to 0 when flush=1; the fetch unit must not hold a dead instruction.
- Normal capture:
  - With id_valid=1, no stall and no flush, all fields latch the forwarded values; latency is 1 cycle.
  - id_valid=0 latches a bubble.
- Pass-through fields: id_i and id_am pass unmodified; sign/shift decoding happens downstream.
- Register-read cases:
  - Reading R15 always takes id_*_data (the PC+8 value), even if some stage writes R15.
  - Multiple hits on the same source resolve by the priority above.
  - Different sources may forward from different stages in the same cycle.

Decomposition:
- Shared package `arm_pipe_pkg` holds:
  - AM encodings (AM_IMM32=2'b00, AM_SHIFT_REG=2'b01, AM_IMM12=2'b10, AM_REG=2'b11);
  - PC_REG;
  - ALU opcode constants;
  - a bubble-constant macro.
- Sub-module `fwd_mux`, instantiated three times:
  - inputs: address, use flag, RF data and the three forwarding ports;
  - outputs: resolved data and an EX-load-hit flag.
- Stall logic and the pipeline register stay in the top module.

Test Plan:
1. Reset: drive all inputs nonzero and hold reset=1 for 1 edge -> every ex_* output is 0; after release, a valid ADD latches next edge.
2. EX forward: id_rm_addr=3, id_rm_data=0x11, ex_rd=3, ex_we=1, ex_fwd_data=0xDEADBEEF, ex_is_load=0 -> ex_rm=0xDEADBEEF after 1 edge, stall=0.
3. Priority: id_rn_addr=5 with ex, mem and wb all writing R5 at 0xA/0xB/0xC -> ex_rn=0xA. Drop ex_we -> ex_rn=0xB.
4. Load-use: ex_is_load=1, ex_rd=2, id_use_rm=1, id_rm_addr=2:
   - stall=1 for one cycle, and a bubble latches (ex_valid=0);
   - next cycle mem_rd=2, mem_fwd_data=0x1234 -> ex_rm=0x1234, ex_valid=1.
5. Flush vs stall: set up the load-use condition of case 4 and assert flush=1 -> stall=0, bubble latched. id_use_rm=0 with the same addresses -> no stall.
6. R15: id_rn_addr=15, id_rn_data=0x108, ex_rd=15, ex_we=1 -> ex_rn=0x108. Immediate path: id_i=12'h26C, id_am=2'b10 -> ex_i=12'h26C, ex_am=2'b10.
